hex_display_monitor: RTL
========================

Name: hex_display_monitor

Overview:
Reader for the four-digit seven-segment bus driven by the clock top level. Samples HEX3..HEX0, debounces digit transitions, and decodes the segment patterns back to BCD. Checks that each displayed value is the legal successor of the previous one, in 24 h or 12 h, HH:MM or MM:SS form. Used as an on-chip self-check and as the bench-side checker for the clock top level.

Parameters:
STABLE_CYCLES, 4, consecutive identical samples required before a display vector is accepted (range 1..255)
ERRW, 8, width of the saturating error counter

Ports:
CP50  input  1  system clock; all logic on its rising edge
CR  input  1  synchronous active-high clear
HEX0  input  7  units digit of low pair; active-low segments {g,f,e,d,c,b,a}
HEX1  input  7  tens digit of low pair
HEX2  input  7  units digit of high pair
HEX3  input  7  tens digit of high pair
Ctrl24To12  input  1  0 = 24 h hours, 1 = 12 h hours
DispSel  input  1  0 = HH:MM shown (HEX3..0 = H1 H0 M1 M0); 1 = MM:SS shown
Digits  output  16  accepted BCD digits {D3,D2,D1,D0}
Valid  output  1  Digits holds a tracked reference
Tick  output  1  one-cycle pulse: accepted value is the correct successor
Err  output  1  one-cycle pulse: wrong successor or out-of-range value
BadSeg  output  1  one-cycle pulse: accepted vector contains an illegal segment code
ErrCnt  output  ERRW  count of Err pulses, saturating at all-ones

Behaviour:
- Reset (CR=1 at a clock edge): Digits=0, Valid=0, Tick=Err=BadSeg=0, ErrCnt=0, sample register = 7'h7F per digit, stability counter=0, FSM=IDLE.
- Segment decode, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- On HEX3 only, blank (1111111) decodes as 0. Any other pattern is illegal.
- Sampling: the 28-bit input vector is registered every cycle into S.
- Stability counter: reset to 0 when the new sample differs from S. Otherwise it increments, saturating at STABLE_CYCLES.
- Accept: one-cycle internal strobe on the edge where the counter reaches STABLE_CYCLES. Fires once per new stable vector.
- Latency: outputs respond on edge k+STABLE_CYCLES+2 for an input change at edge k.
- FSM IDLE, on accept of a legal, in-range vector: load Digits, Valid=1, go to TRACK. No Tick or Err.
- FSM TRACK, on accept:
  - Illegal code: BadSeg pulse; Digits and state unchanged.
  - Equal to reference: no action.
  - Equals the expected successor: Tick, Digits updated.
  - Otherwise (in range but not the successor): Err, ErrCnt+1, Digits resynced to the new value, stay in TRACK.
- Out of range (any state): Err, ErrCnt+1, Valid=0, go to IDLE.
- Ranges:
  - Minutes and seconds: 00..59.
  - Hours, 24 h: 00..23. Hours, 12 h: 01..12.
  - Each BCD digit must be 0..9; the tens digit is bounded by the field range.
- Successor, low pair != 59: low+1 (BCD carry 09->10), high unchanged.
- Successor, low pair = 59: low=00, high advances.
  - HH:MM mode: 23->00 (24 h); 11->12 and 12->01 (12 h).
  - MM:SS mode: 59->00.
- Mode change: any change of Ctrl24To12 or DispSel (registered, compared with the previous value) forces IDLE and Valid=0 on the next edge. An accept in the same cycle is discarded.
- Simultaneous Err and saturated ErrCnt: Err still pulses, ErrCnt holds.
- CR mid-operation overrides everything, including an accept in the same cycle.

Test Plan:
1. CR pulse, then HEX = "12:34" (24 h, HH:MM) held 10 cycles -> Valid=1 at edge 6 after change, Digits=16'h1234, no Tick/Err.
2. From 23:59 go to 00:00 (24 h) -> Tick, Digits=16'h0000. Repeat in 12 h from 12:59 to 01:00 -> Tick, Digits=16'h0100.
3. From 10:15 jump to 10:17 -> Err, ErrCnt=1, Digits=16'h1017. Then 10:18 -> Tick.
4. Glitch HEX0 to 7 for 2 cycles, then back to 4 (STABLE_CYCLES=4) -> no accept, no pulses, Digits unchanged.
5. HEX1 = 1111111 held stable -> BadSeg pulse, Digits unchanged. HEX = "25:00" in 24 h -> Err, Valid=0.
6. Toggle DispSel while tracking -> Valid=0 next edge. Stable "59:58" MM:SS, then "59:59", then "00:00" -> Tick, Tick. Force 300 errors with ERRW=8 -> ErrCnt=255.

Source files
------------

// File: rtl/hex_display_monitor.sv
// hex_display_monitor: samples and debounces a four-digit seven-segment bus, decodes it to BCD
// and checks each accepted display value against the legal clock successor.
module hex_display_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERRW = 8
) (
  input  logic            CP50,
  input  logic            CR,
  input  logic [6:0]      HEX0,
  input  logic [6:0]      HEX1,
  input  logic [6:0]      HEX2,
  input  logic [6:0]      HEX3,
  input  logic            Ctrl24To12,
  input  logic            DispSel,
  output logic [15:0]     Digits,
  output logic            Valid,
  output logic            Tick,
  output logic            Err,
  output logic            BadSeg,
  output logic [ERRW-1:0] ErrCnt
);
  typedef enum logic {IDLE, TRACK} state_t;
  localparam logic [7:0] SC = 8'(STABLE_CYCLES);
  state_t state;
  logic [27:0] hex, s;
  logic [7:0] cnt;
  logic acc;
  logic [1:0] mode, mode_q;
  logic [4:0] c3, c2, c1, c0;
  logic legal, in_range, wrap;
  logic [6:0] nh, nl, rh, rl, sh, sl;
  logic [15:0] nd;
  // {legal, bcd}; blank is only meaningful as a suppressed leading zero
  function automatic logic [4:0] dec(input logic [6:0] seg, input logic blank_ok);
    case (seg)
      7'b1000000: dec = 5'h10;
      7'b1111001: dec = 5'h11;
      7'b0100100: dec = 5'h12;
      7'b0110000: dec = 5'h13;
      7'b0011001: dec = 5'h14;
      7'b0010010: dec = 5'h15;
      7'b0000010: dec = 5'h16;
      7'b1111000: dec = 5'h17;
      7'b0000000: dec = 5'h18;
      7'b0010000: dec = 5'h19;
      7'b1111111: dec = {blank_ok, 4'd0};
      default:    dec = 5'h00;
    endcase
  endfunction
  function automatic logic [6:0] num(input logic [3:0] t, input logic [3:0] u);
    return 7'(t) * 7'd10 + 7'(u);
  endfunction
  assign hex  = {HEX3, HEX2, HEX1, HEX0};
  assign mode = {Ctrl24To12, DispSel};
  always_comb begin
    c3 = dec(s[27:21], 1'b1);
    c2 = dec(s[20:14], 1'b0);
    c1 = dec(s[13:7], 1'b0);
    c0 = dec(s[6:0], 1'b0);
    legal = c3[4] & c2[4] & c1[4] & c0[4];
    nd = {c3[3:0], c2[3:0], c1[3:0], c0[3:0]};
    nh = num(c3[3:0], c2[3:0]);
    nl = num(c1[3:0], c0[3:0]);
    rh = num(Digits[15:12], Digits[11:8]);
    rl = num(Digits[7:4], Digits[3:0]);
    wrap = rl == 7'd59;
    sl = wrap ? 7'd0 : rl + 7'd1;
    sh = !wrap ? rh :
         DispSel ? (rh == 7'd59 ? 7'd0 : rh + 7'd1) :
         Ctrl24To12 ? (rh == 7'd12 ? 7'd1 : rh + 7'd1) :
         (rh == 7'd23 ? 7'd0 : rh + 7'd1);
    in_range = nl <= 7'd59 && (DispSel ? nh <= 7'd59 :
               Ctrl24To12 ? (nh >= 7'd1 && nh <= 7'd12) : nh <= 7'd23);
  end
  always_ff @(posedge CP50) begin
    if (CR) begin
      state  <= IDLE;
      s      <= '1;
      cnt    <= '0;
      acc    <= 1'b0;
      mode_q <= mode;
      Digits <= '0;
      Valid  <= 1'b0;
      Tick   <= 1'b0;
      Err    <= 1'b0;
      BadSeg <= 1'b0;
      ErrCnt <= '0;
    end else begin
      s      <= hex;
      cnt    <= hex != s ? 8'd0 : cnt == SC ? cnt : cnt + 8'd1;
      acc    <= hex == s && cnt == SC - 8'd1;
      mode_q <= mode;
      Tick   <= 1'b0;
      Err    <= 1'b0;
      BadSeg <= 1'b0;
      if (mode != mode_q) begin
        state <= IDLE;
        Valid <= 1'b0;
      end else if (acc) begin
        if (!legal) BadSeg <= 1'b1;
        else if (!in_range) begin
          Err    <= 1'b1;
          ErrCnt <= &ErrCnt ? ErrCnt : ErrCnt + ERRW'(1);
          Valid  <= 1'b0;
          state  <= IDLE;
        end else if (state == IDLE) begin
          Digits <= nd;
          Valid  <= 1'b1;
          state  <= TRACK;
        end else if (nd != Digits) begin
          Digits <= nd;
          if (nh == sh && nl == sl) Tick <= 1'b1;
          else begin
            Err    <= 1'b1;
            ErrCnt <= &ErrCnt ? ErrCnt : ErrCnt + ERRW'(1);
          end
        end
      end
    end
  end
endmodule
